iter_shifter: RTL and testbench

//  Multi-cycle logarithmic shifter for the processor's shift unit.

---
 rtl/iter_shifter_pkg.sv | 17 +
 rtl/iter_shifter_stage.sv | 31 +++
 rtl/iter_shifter.sv | 126 ++++++++++++
 tb/tb_iter_shifter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/iter_shifter_pkg.sv
// Shared encodings for the iterative shifter: operation codes and FSM states.
package iter_shifter_pkg;

  typedef enum logic [1:0] {
    OpSll = 2'b00,
    OpSrl = 2'b01,
    OpSra = 2'b10,
    OpRol = 2'b11
  } shift_op_e;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StDone = 2'b10
  } shift_state_e;

endpackage

// File: rtl/iter_shifter_stage.sv
// One barrel stage: conditionally shifts/rotates the operand by 2^K.
module iter_shifter_stage
  import iter_shifter_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned K     = 0
) (
  input  logic             en,
  input  shift_op_e        op,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o
);

  localparam int unsigned Dist = 2 ** K;

  logic [WIDTH-1:0] shifted;

  // Shifted candidate for the selected op; passed through when the shamt bit is clear.
  always_comb begin
    shifted = data_i;
    unique case (op)
      OpSll: shifted = data_i << Dist;
      OpSrl: shifted = data_i >> Dist;
      // The operand MSB is the latched sign, so arithmetic shifting keeps filling with it.
      OpSra: shifted = $signed(data_i) >>> Dist;
      OpRol: shifted = (data_i << Dist) | (data_i >> (WIDTH - Dist));
    endcase
    data_o = en ? shifted : data_i;
  end

endmodule

// File: rtl/iter_shifter.sv
// Multi-cycle logarithmic shifter with a start/busy/done handshake.
// Applies STAGES_PER_CYCLE barrel stages per RUN cycle to an accumulator.
module iter_shifter
  import iter_shifter_pkg::*;
#(
  parameter int unsigned WIDTH            = 32,
  parameter int unsigned SHAMT_W          = 5,
  parameter int unsigned STAGES_PER_CYCLE = 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               ctrl_shift,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   data_in,
  input  logic [SHAMT_W-1:0] shamt,
  output logic [WIDTH-1:0]   result,
  output logic               busy,
  output logic               data_resultRDY
);

  localparam int          Stages = int'(STAGES_PER_CYCLE);
  localparam int          ShW    = int'(SHAMT_W);
  localparam int unsigned CntW   = $clog2(SHAMT_W + 1);
  localparam logic [CntW-1:0] KStep = CntW'(STAGES_PER_CYCLE);

  shift_state_e       state_q;
  logic [CntW-1:0]    k_q;
  logic [WIDTH-1:0]   acc_q;
  shift_op_e          op_q;
  logic [SHAMT_W-1:0] shamt_q;
  logic [WIDTH-1:0]   result_q;
  logic               busy_q;
  logic               rdy_q;

  logic [WIDTH-1:0] stage_in  [SHAMT_W];
  logic [WIDTH-1:0] stage_out [SHAMT_W];
  logic [WIDTH-1:0] acc_step;
  logic             last_run;
  logic             start;
  int               last_idx;

  // Stages are chained within a cycle group; the first stage of each group reads acc.
  for (genvar j = 0; j < SHAMT_W; j++) begin : g_stage
    if ((j % STAGES_PER_CYCLE) == 0) begin : g_head
      assign stage_in[j] = acc_q;
    end else begin : g_chain
      assign stage_in[j] = stage_out[j-1];
    end
    iter_shifter_stage #(
      .WIDTH (WIDTH),
      .K     (j)
    ) u_stage (
      .en     (shamt_q[j]),
      .op     (op_q),
      .data_i (stage_in[j]),
      .data_o (stage_out[j])
    );
  end

  // Pick the output of the last stage due this cycle; a short final group stops at SHAMT_W-1.
  always_comb begin
    last_idx = int'(k_q) + Stages - 1;
    if (last_idx > ShW - 1) begin
      last_idx = ShW - 1;
    end
    acc_step = acc_q;
    for (int j = 0; j < ShW; j++) begin
      if (j == last_idx) begin
        acc_step = stage_out[j];
      end
    end
    last_run = (int'(k_q) + Stages) >= ShW;
  end

  // Starts are honoured in IDLE and DONE only; a pulse during RUN is dropped.
  assign start = ctrl_shift && (state_q != StRun);

  // FSM, stage counter, accumulator and registered handshake outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= StIdle;
      k_q      <= '0;
      acc_q    <= '0;
      op_q     <= OpSll;
      shamt_q  <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      rdy_q <= 1'b0;
      unique case (state_q)
        StIdle: ;
        StRun: begin
          acc_q <= acc_step;
          if (last_run) begin
            state_q <= StDone;
            k_q     <= '0;
            busy_q  <= 1'b0;
          end else begin
            k_q <= k_q + KStep;
          end
        end
        StDone: begin
          result_q <= acc_q;
          rdy_q    <= 1'b1;
          state_q  <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
      // Placed last so a back-to-back start in DONE overrides the return to IDLE.
      if (start) begin
        acc_q   <= data_in;
        op_q    <= shift_op_e'(op);
        shamt_q <= shamt;
        k_q     <= '0;
        busy_q  <= 1'b1;
        state_q <= StRun;
      end
    end
  end

  assign result         = result_q;
  assign busy           = busy_q;
  assign data_resultRDY = rdy_q;

endmodule

// File: tb/tb_iter_shifter.sv
// Scoreboard bench for iter_shifter at STAGES_PER_CYCLE = 1, 2 and 5.
module tb_iter_shifter;

  logic        clock = 1'b0;
  logic        reset;
  logic        ctrl   [3];
  logic [1:0]  op_s   [3];
  logic [31:0] din    [3];
  logic [4:0]  sh     [3];
  logic [31:0] res_w  [3];
  logic        busy_w [3];
  logic        rdy_w  [3];

  always #5 clock = ~clock;

  iter_shifter #(.WIDTH(32), .SHAMT_W(5), .STAGES_PER_CYCLE(1)) dut_s1 (
    .clock(clock), .reset(reset), .ctrl_shift(ctrl[0]), .op(op_s[0]), .data_in(din[0]),
    .shamt(sh[0]), .result(res_w[0]), .busy(busy_w[0]), .data_resultRDY(rdy_w[0])
  );
  iter_shifter #(.WIDTH(32), .SHAMT_W(5), .STAGES_PER_CYCLE(2)) dut_s2 (
    .clock(clock), .reset(reset), .ctrl_shift(ctrl[1]), .op(op_s[1]), .data_in(din[1]),
    .shamt(sh[1]), .result(res_w[1]), .busy(busy_w[1]), .data_resultRDY(rdy_w[1])
  );
  iter_shifter #(.WIDTH(32), .SHAMT_W(5), .STAGES_PER_CYCLE(5)) dut_s5 (
    .clock(clock), .reset(reset), .ctrl_shift(ctrl[2]), .op(op_s[2]), .data_in(din[2]),
    .shamt(sh[2]), .result(res_w[2]), .busy(busy_w[2]), .data_resultRDY(rdy_w[2])
  );

  typedef struct {
    int          inst;
    logic [31:0] res;
    int          cyc;
  } exp_t;

  exp_t sbq[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic int lat(input int i);
    case (i)
      0:       return 6;
      1:       return 4;
      default: return 2;
    endcase
  endfunction

  // Bit-at-a-time reference model.
  function automatic logic [31:0] ref_shift(input logic [1:0] o, input logic [31:0] d,
                                            input logic [4:0] s);
    logic [31:0] r;
    r = d;
    for (int n = 0; n < int'(s); n++) begin
      case (o)
        2'd0:    r = {r[30:0], 1'b0};
        2'd1:    r = {1'b0, r[31:1]};
        2'd2:    r = {r[31], r[31:1]};
        default: r = {r[30:0], r[31]};
      endcase
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  // Pulse ctrl_shift on instance i; when track is set, push the expected completion.
  task automatic start(input int i, input logic [1:0] o, input logic [31:0] d,
                       input logic [4:0] s, input logic [31:0] expv, input bit track);
    exp_t e;
    @(negedge clock);
    ctrl[i] = 1'b1;
    op_s[i] = o;
    din[i]  = d;
    sh[i]   = s;
    @(posedge clock);
    #1;
    ctrl[i] = 1'b0;
    if (track) begin
      e.inst = i;
      e.res  = expv;
      e.cyc  = cyc + lat(i);
      sbq.push_back(e);
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 40) begin
      @(posedge clock);
      n++;
    end
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL %s: timeout, %0d results pending, required 0", name, sbq.size());
      sbq.delete();
    end
    repeat (2) @(negedge clock);
  endtask

  task automatic mon(input int i);
    exp_t e;
    checks++;
    if (sbq.size() == 0) begin
      errors++;
      $display("FAIL unexpected_done: inst %0d result %h at cycle %0d, required no pulse",
               i, res_w[i], cyc);
    end else begin
      e = sbq.pop_front();
      if (e.inst != i || res_w[i] !== e.res || cyc != e.cyc) begin
        errors++;
        $display("FAIL done_result: inst %0d result %h cycle %0d, required inst %0d %h cycle %0d",
                 i, res_w[i], cyc, e.inst, e.res, e.cyc);
      end
    end
  endtask

  // Monitor: every done pulse is matched against the scoreboard head.
  always @(negedge clock) begin
    for (int i = 0; i < 3; i++) begin
      if (rdy_w[i] === 1'b1) mon(i);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  o;
    logic [31:0] d;
    logic [4:0]  s;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ctrl[i] = 1'b0;
      op_s[i] = 2'd0;
      din[i]  = 32'h0;
      sh[i]   = 5'd0;
    end
    repeat (2) @(posedge clock);
    @(negedge clock);
    for (int i = 0; i < 3; i++) begin
      chk("reset_result", res_w[i], 32'h0);
      chk("reset_busy", {31'b0, busy_w[i]}, 32'h0);
      chk("reset_rdy", {31'b0, rdy_w[i]}, 32'h0);
    end
    reset = 1'b0;

    // Directed vectors, one start per operation.
    start(0, 2'b00, 32'h0000_0001, 5'd31, 32'h8000_0000, 1'b1);
    chk("busy_in_run", {31'b0, busy_w[0]}, 32'h1);
    drain("sll31");
    start(0, 2'b10, 32'h8000_00F0, 5'd4, 32'hF800_000F, 1'b1);
    drain("sra4");
    start(0, 2'b01, 32'h8000_00F0, 5'd4, 32'h0800_000F, 1'b1);
    drain("srl4");
    start(0, 2'b11, 32'h8000_0001, 5'd1, 32'h0000_0003, 1'b1);
    drain("rol1");
    start(0, 2'b11, 32'h8000_0001, 5'd0, 32'h8000_0001, 1'b1);
    drain("rol0");
    start(0, 2'b10, 32'hF000_0000, 5'd28, 32'hFFFF_FFFF, 1'b1);
    drain("sra28");
    start(0, 2'b01, 32'hFFFF_FFFF, 5'd31, 32'h0000_0001, 1'b1);
    drain("srl31");

    // A start pulse during RUN is ignored.
    start(0, 2'b00, 32'h0000_0001, 5'd5, 32'h0000_0020, 1'b1);
    @(negedge clock);
    start(0, 2'b00, 32'h0000_0001, 5'd9, 32'h0, 1'b0);
    chk("busy_after_ignored", {31'b0, busy_w[0]}, 32'h1);
    drain("ignored_start");

    // Back-to-back: second start lands on the DONE cycle of the first.
    start(0, 2'b01, 32'hF000_0000, 5'd4, 32'h0F00_0000, 1'b1);
    repeat (5) @(negedge clock);
    start(0, 2'b11, 32'h1234_5678, 5'd8, 32'h3456_7812, 1'b1);
    drain("back_to_back");

    // Reset three cycles into RUN aborts without a done pulse.
    start(0, 2'b00, 32'hDEAD_BEEF, 5'd16, 32'h0, 1'b0);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    chk("abort_busy", {31'b0, busy_w[0]}, 32'h0);
    chk("abort_result", res_w[0], 32'h0);
    chk("abort_rdy", {31'b0, rdy_w[0]}, 32'h0);
    repeat (10) @(negedge clock);

    // Reset and start on the same edge: reset wins.
    ctrl[0] = 1'b1;
    reset   = 1'b1;
    @(posedge clock);
    #1;
    ctrl[0] = 1'b0;
    reset   = 1'b0;
    chk("reset_beats_start", {31'b0, busy_w[0]}, 32'h0);
    repeat (10) @(negedge clock);

    start(0, 2'b00, 32'hDEAD_BEEF, 5'd16, 32'hBEEF_0000, 1'b1);
    drain("after_abort");

    // Wider per-cycle stage groups, including a partial final group.
    for (int i = 1; i < 3; i++) begin
      start(i, 2'b00, 32'h0000_0001, 5'd31, 32'h8000_0000, 1'b1);
      drain("multi_sll31");
      start(i, 2'b11, 32'h1234_5678, 5'd8, 32'h3456_7812, 1'b1);
      drain("multi_rol8");
      start(i, 2'b10, 32'h8000_00F0, 5'd4, 32'hF800_000F, 1'b1);
      drain("multi_sra4");
    end

    // Randomised vectors against the reference model.
    for (int i = 0; i < 3; i++) begin
      for (int n = 0; n < 60; n++) begin
        o = 2'($urandom_range(0, 3));
        d = $urandom;
        s = 5'($urandom_range(0, 31));
        start(i, o, d, s, ref_shift(o, d, s), 1'b1);
        drain("random");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
